// File: rtl/mul_pkg.sv
// Shared types for the shift-add multiplier: controller states and counter-width helper.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mul_state_t;

    function automatic int unsigned cnt_w(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/shift_add_dp.sv
// Shift-add datapath: shifted multiplicand A, multiplier B, accumulator and iteration count.
module shift_add_dp
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               clr,
    input  logic [WIDTH-1:0]   a_ld,
    input  logic [WIDTH-1:0]   b_ld,
    output logic [2*WIDTH-1:0] acc,
    output logic               bz,
    output logic               cz
);

    localparam int unsigned CW = cnt_w(WIDTH);

    logic [2*WIDTH-1:0] a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [CW-1:0]      cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            cnt  <= '0;
        end else if (clr) begin
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            cnt  <= '0;
        end else if (load) begin
            a_sh <= {{WIDTH{1'b0}}, a_ld};
            b_sh <= b_ld;
            acc  <= '0;
            cnt  <= CW'(WIDTH);
        end else if (step) begin
            if (b_sh[0]) begin
                acc <= acc + a_sh;
            end
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt - 1'b1;
        end
    end

    assign bz = (b_sh == '0);
    assign cz = (cnt == '0);

endmodule

// File: rtl/shift_add_mul.sv
// Sequential shift-add multiplier with start/done handshake and early termination.
// Optional two's-complement operands when MUL_SIGNED_EN is defined.
module shift_add_mul
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    mul_state_t         state, next_state;
    logic               load, step, clr;
    logic               bz, cz;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] result;

`ifdef MUL_SIGNED_EN
    logic sign;

    // Magnitude of the most negative value wraps to 2^(WIDTH-1), which reads correctly as unsigned.
    assign a_mag  = a_in[WIDTH-1] ? -a_in : a_in;
    assign b_mag  = b_in[WIDTH-1] ? -b_in : b_in;
    assign result = sign ? -acc : acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign <= 1'b0;
        end else if (load) begin
            sign <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
        end
    end
`else
    assign a_mag  = a_in;
    assign b_mag  = b_in;
    assign result = acc;
`endif

    shift_add_dp #(.WIDTH(WIDTH)) u_dp (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .clr  (clr),
        .a_ld (a_mag),
        .b_ld (b_mag),
        .acc  (acc),
        .bz   (bz),
        .cz   (cz)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        clr        = 1'b0;
        ready      = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    next_state = CALC;
                end
            end
            CALC: begin
                if (bz || cz) begin
                    next_state = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                done       = 1'b1;
                clr        = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product <= '0;
        end else if (load) begin
            product <= '0;
        end else if (state == CALC && (bz || cz)) begin
            product <= result;
        end
    end

endmodule

// File: tb/tb_shift_add_mul.sv
// Scoreboard bench for shift_add_mul at WIDTH=8; honours MUL_SIGNED_EN like the design.
module tb_shift_add_mul;

    localparam int unsigned W = 8;

    typedef struct {
        logic [2*W-1:0] prod;
        int unsigned    lat;
        longint unsigned start_cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   a_in, b_in;
    logic           ready, done;
    logic [2*W-1:0] product;

    int unsigned     checks = 0;
    int unsigned     errors = 0;
    longint unsigned cyc = 0;
    exp_t            exp_q[$];
    logic [2*W-1:0]  last_prod;
    bit              ready_due = 1'b0;

    shift_add_mul #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .ready   (ready),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: plain arithmetic on the (sign-interpreted) operands.
    function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] ea, eb;
`ifdef MUL_SIGNED_EN
        ea = {{W{a[W-1]}}, a};
        eb = {{W{b[W-1]}}, b};
`else
        ea = {{W{1'b0}}, a};
        eb = {{W{1'b0}}, b};
`endif
        return ea * eb;
    endfunction

    function automatic int unsigned model_len(input logic [W-1:0] b);
        logic [W-1:0] mag;
        int unsigned  len;
        mag = b;
`ifdef MUL_SIGNED_EN
        if (b[W-1]) mag = -b;
`endif
        len = 0;
        for (int unsigned i = 0; i < W; i++) begin
            if (mag[i]) len = i + 1;
        end
        return len;
    endfunction

    always @(negedge clk) begin
        if (ready_due) begin
            chk("ready_return", ready, 1);
            ready_due = 1'b0;
        end
        chk("ready_done_excl", ready && done, 0);
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("product", product, e.prod);
                chk("latency", cyc - e.start_cyc, e.lat);
                ready_due = 1'b1;
            end
        end
    end

    task automatic wait_ready();
        int unsigned n = 0;
        while (!ready && n < 4 * W) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        exp_t        e;
        int unsigned n;
        wait_ready();
        chk("product_held", product, last_prod);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.prod      = model_prod(a, b);
        e.lat       = model_len(b) + 1;
        e.start_cyc = cyc;
        exp_q.push_back(e);
        last_prod = e.prod;
        if (!hold) start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            if (hold) begin
                a_in = W'($urandom);
                b_in = W'($urandom);
            end
            n++;
        end while (!done && n < 4 * W);
        start = 1'b0;
        if (!done) begin
            chk("done_timeout", 0, 1);
            exp_q.delete();
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            last_prod = '0;
        end
    endtask

    task automatic abort_mid_calc(input logic [W-1:0] a, input logic [W-1:0] b);
        wait_ready();
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_product", product, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", ready, 1);
        @(negedge clk);
        rst = 1'b0;
        last_prod = '0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        last_prod = '0;
        repeat (2) @(negedge clk);
        chk("reset_product", product, 0);
        chk("reset_ready", ready, 1);
        chk("reset_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        issue(8'd13, 8'd11, 1'b0);
        issue(8'hFF, 8'hFF, 1'b0);
        issue(8'd200, 8'd0, 1'b1);
        issue(8'd3, 8'd5, 1'b0);
        abort_mid_calc(8'hAB, 8'hCD);
        issue(8'd2, 8'd3, 1'b0);
`ifdef MUL_SIGNED_EN
        issue(8'h80, 8'h80, 1'b0);
        issue(8'hF9, 8'd9, 1'b0);
        issue(8'd5, 8'hFF, 1'b0);
`endif

        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] ra, rb, mask;
            int unsigned  bits;
            bits = $urandom_range(0, W);
            mask = (bits == W) ? '1 : W'((32'd1 << bits) - 1);
            ra   = W'($urandom);
            rb   = W'($urandom) & mask;
            if ((i % 7) == 0) ra = '0;
            issue(ra, rb, ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
